// File: rtl/dsram_port_arbiter_if.sv
// Request/response bundle between the core pipeline and the data-SRAM port arbiter.
// master: core side (EX loads, MS stores, SRAM consumer); slave: the arbiter.
interface dsram_port_arbiter_if;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_gnt;
  logic        ld_stall;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        st_ready;
  logic        sq_empty;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  modport master (
    output ld_req, ld_addr, st_req, st_addr, st_wdata, st_wstrb,
    input  ld_gnt, ld_stall, st_ready, sq_empty,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  ld_req, ld_addr, st_req, st_addr, st_wdata, st_wstrb,
    output ld_gnt, ld_stall, st_ready, sq_empty,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/dsram_port_arbiter.sv
// Data-SRAM port arbiter: loads get the single port unless they hit a queued
// store (RAW) or the store queue is full; stores wait in a circular queue and
// drain whenever the port is not granted to a load.
// Optional starvation guard: define DSRAM_STARVE_GUARD_EN.
module dsram_port_arbiter #(
  parameter int unsigned SQ_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                 clk,
  input logic                 resetn,
  dsram_port_arbiter_if.slave bus
);
  localparam int unsigned PW       = $clog2(SQ_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(SQ_DEPTH);

  if ((SQ_DEPTH < 2) || ((SQ_DEPTH & (SQ_DEPTH - 1)) != 0) || (STARVE_LIMIT == 0)) begin : g_bad_cfg
    $error("dsram_port_arbiter: SQ_DEPTH must be a power of two >= 2, STARVE_LIMIT > 0");
  end

  logic [31:0]         sq_addr  [SQ_DEPTH];
  logic [31:0]         sq_wdata [SQ_DEPTH];
  logic [3:0]          sq_wstrb [SQ_DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [PW:0]         count;
  logic [SQ_DEPTH-1:0] sq_valid;
  logic                empty;
  logic                full;
  logic                enq;
  logic                haz;
  logic                starve_hit;
  logic                drain_force;
  logic                ld_gnt;
  logic                drain;

  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign enq         = bus.st_req & ~full;
  assign drain_force = full | starve_hit;

  // An entry is live when its distance from head is below the occupancy count.
  always_comb begin
    sq_valid = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      sq_valid[i] = ({1'b0, PW'(PW'(i) - head)} < count);
    end
  end

  // RAW hazard: load word matches a live entry or the store being accepted now.
  always_comb begin
    haz = enq & (bus.st_addr[31:2] == bus.ld_addr[31:2]);
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      if (sq_valid[i] && (sq_addr[i][31:2] == bus.ld_addr[31:2])) haz = 1'b1;
    end
  end

`ifdef DSRAM_STARVE_GUARD_EN
  localparam int unsigned       SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_cnt;

  // Count cycles the queue holds data without draining; saturate at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                 starve_cnt <= '0;
    else if (drain)                              starve_cnt <= '0;
    else if (!empty && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
  end

  assign starve_hit = (starve_cnt == STARVE_MAX);
`else
  assign starve_hit = 1'b0;
`endif

  // Port arbitration. The grant is masked by resetn so the port is idle
  // immediately on an asynchronous reset even while ld_req is still asserted.
  always_comb begin
    ld_gnt              = bus.ld_req & resetn & ~haz & ~drain_force;
    drain               = ~empty & ~ld_gnt;
    bus.ld_gnt          = ld_gnt;
    bus.ld_stall        = bus.ld_req & resetn & ~ld_gnt;
    bus.st_ready        = ~full;
    bus.sq_empty        = empty;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_we    = '0;
    bus.data_sram_addr  = '0;
    bus.data_sram_wdata = '0;
    if (ld_gnt) begin
      bus.data_sram_en   = 1'b1;
      bus.data_sram_addr = bus.ld_addr;
    end else if (drain) begin
      bus.data_sram_en    = 1'b1;
      bus.data_sram_we    = sq_wstrb[head];
      bus.data_sram_addr  = {sq_addr[head][31:2], 2'b00};
      bus.data_sram_wdata = sq_wdata[head];
    end
  end

  // Queue pointers and occupancy; simultaneous enqueue and drain keep count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)   tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      if (enq && !drain)      count <= count + 1'b1;
      else if (!enq && drain) count <= count - 1'b1;
    end
  end

  // Store-queue payload; only live entries are ever read.
  always_ff @(posedge clk) begin
    if (enq) begin
      sq_addr[tail]  <= bus.st_addr;
      sq_wdata[tail] <= bus.st_wdata;
      sq_wstrb[tail] <= bus.st_wstrb;
    end
  end
endmodule

// File: tb/tb_dsram_port_arbiter.sv
// Directed bench for dsram_port_arbiter (SQ_DEPTH=4, STARVE_LIMIT=8).
// Build with +define+DSRAM_STARVE_GUARD_EN to exercise the starvation guard.
module tb_dsram_port_arbiter;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  dsram_port_arbiter_if bus();

  dsram_port_arbiter #(.SQ_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

`ifdef DSRAM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int drains;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_ld(input logic req, input logic [31:0] a);
    bus.ld_req  = req;
    bus.ld_addr = a;
  endtask

  task automatic drive_st(input logic req, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.st_req   = req;
    bus.st_addr  = a;
    bus.st_wdata = d;
    bus.st_wstrb = s;
  endtask

  initial begin
    resetn = 1'b0;
    drive_ld(1'b0, '0);
    drive_st(1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
    chk("rst_sq_empty", 32'(bus.sq_empty), 32'd1);
    chk("rst_en",       32'(bus.data_sram_en), 32'd0);
    chk("rst_gnt",      32'(bus.ld_gnt), 32'd0);
    chk("rst_stall",    32'(bus.ld_stall), 32'd0);
    chk("rst_we",       32'(bus.data_sram_we), 32'd0);
    chk("rst_addr",     bus.data_sram_addr, 32'd0);
    chk("rst_wdata",    bus.data_sram_wdata, 32'd0);
    resetn = 1'b1;
    tick();

    // Store with idle port: reaches SRAM the cycle after enqueue.
    drive_st(1'b1, 32'h100, 32'hA5A5_A5A5, 4'hF);
    sample();
    chk("st_idle_ready",    32'(bus.st_ready), 32'd1);
    chk("st_idle_nobypass", 32'(bus.data_sram_en), 32'd0);
    tick();
    drive_st(1'b0, '0, '0, '0);
    sample();
    chk("st_idle_en",    32'(bus.data_sram_en), 32'd1);
    chk("st_idle_we",    32'(bus.data_sram_we), 32'hF);
    chk("st_idle_addr",  bus.data_sram_addr, 32'h100);
    chk("st_idle_wdata", bus.data_sram_wdata, 32'hA5A5_A5A5);
    tick();
    sample();
    chk("st_idle_empty", 32'(bus.sq_empty), 32'd1);
    chk("st_idle_en_off", 32'(bus.data_sram_en), 32'd0);
    tick();

    // Load priority over a queued non-matching store.
    drive_st(1'b1, 32'h200, 32'h1111_2222, 4'hF);
    drive_ld(1'b1, 32'h300);
    sample();
    chk("ldpri_gnt0",  32'(bus.ld_gnt), 32'd1);
    chk("ldpri_we0",   32'(bus.data_sram_we), 32'd0);
    chk("ldpri_addr0", bus.data_sram_addr, 32'h300);
    tick();
    drive_st(1'b0, '0, '0, '0);
    for (int i = 1; i < 3; i++) begin
      sample();
      chk("ldpri_gnt",   32'(bus.ld_gnt), 32'd1);
      chk("ldpri_we",    32'(bus.data_sram_we), 32'd0);
      chk("ldpri_queued", 32'(bus.sq_empty), 32'd0);
      tick();
    end
    drive_ld(1'b0, '0);
    sample();
    chk("ldpri_drain_we",    32'(bus.data_sram_we), 32'hF);
    chk("ldpri_drain_addr",  bus.data_sram_addr, 32'h200);
    chk("ldpri_drain_wdata", bus.data_sram_wdata, 32'h1111_2222);
    tick();
    sample();
    chk("ldpri_empty", 32'(bus.sq_empty), 32'd1);
    tick();

    // RAW hazard on a queued entry: store drains first, then the load.
    drive_st(1'b1, 32'h400, 32'h0000_BEEF, 4'h3);
    tick();
    drive_st(1'b0, '0, '0, '0);
    drive_ld(1'b1, 32'h402);
    sample();
    chk("raw_gnt0",   32'(bus.ld_gnt), 32'd0);
    chk("raw_stall0", 32'(bus.ld_stall), 32'd1);
    chk("raw_we0",    32'(bus.data_sram_we), 32'h3);
    chk("raw_addr0",  bus.data_sram_addr, 32'h400);
    chk("raw_wdata0", bus.data_sram_wdata, 32'h0000_BEEF);
    tick();
    sample();
    chk("raw_gnt1",   32'(bus.ld_gnt), 32'd1);
    chk("raw_stall1", 32'(bus.ld_stall), 32'd0);
    chk("raw_addr1",  bus.data_sram_addr, 32'h402);
    chk("raw_we1",    32'(bus.data_sram_we), 32'd0);
    tick();

    // RAW hazard against the store being accepted in the same cycle.
    drive_st(1'b1, 32'h501, 32'hCAFE_0000, 4'hC);
    drive_ld(1'b1, 32'h503);
    sample();
    chk("rawin_stall", 32'(bus.ld_stall), 32'd1);
    chk("rawin_en",    32'(bus.data_sram_en), 32'd0);
    tick();
    drive_st(1'b0, '0, '0, '0);
    sample();
    chk("rawin_stall1", 32'(bus.ld_stall), 32'd1);
    chk("rawin_we",     32'(bus.data_sram_we), 32'hC);
    chk("rawin_addr",   bus.data_sram_addr, 32'h500);
    tick();
    sample();
    chk("rawin_gnt",  32'(bus.ld_gnt), 32'd1);
    chk("rawin_addr2", bus.data_sram_addr, 32'h503);
    tick();

    // Full queue: forced drain over a ready load, st_ready low that cycle.
    drive_ld(1'b1, 32'h800);
    for (int i = 1; i <= 4; i++) begin
      drive_st(1'b1, 32'(i * 16), 32'(i), 4'hF);
      sample();
      chk("full_fill_ready", 32'(bus.st_ready), 32'd1);
      chk("full_fill_gnt",   32'(bus.ld_gnt), 32'd1);
      tick();
    end
    drive_st(1'b1, 32'h50, 32'd5, 4'hF);
    sample();
    chk("full_ready",  32'(bus.st_ready), 32'd0);
    chk("full_gnt",    32'(bus.ld_gnt), 32'd0);
    chk("full_stall",  32'(bus.ld_stall), 32'd1);
    chk("full_we",     32'(bus.data_sram_we), 32'hF);
    chk("full_addr",   bus.data_sram_addr, 32'h10);
    chk("full_wdata",  bus.data_sram_wdata, 32'd1);
    tick();
    sample();
    chk("full_ready_next", 32'(bus.st_ready), 32'd1);
    chk("full_gnt_next",   32'(bus.ld_gnt), 32'd1);
    tick();
    drive_st(1'b0, '0, '0, '0);
    sample();
    chk("full2_ready", 32'(bus.st_ready), 32'd0);
    chk("full2_addr",  bus.data_sram_addr, 32'h20);
    tick();
    drive_ld(1'b0, '0);
    for (int i = 3; i <= 5; i++) begin
      sample();
      chk("full_order_addr",  bus.data_sram_addr, 32'(i * 16));
      chk("full_order_wdata", bus.data_sram_wdata, 32'(i));
      tick();
    end
    sample();
    chk("full_empty", 32'(bus.sq_empty), 32'd1);
    tick();

    // Starvation: one store queued behind a continuous non-matching load stream.
    drive_st(1'b1, 32'h900, 32'h7777_7777, 4'hF);
    drive_ld(1'b1, 32'hA00);
    sample();
    chk("starve_gnt0", 32'(bus.ld_gnt), 32'd1);
    tick();
    drive_st(1'b0, '0, '0, '0);
    drains = 0;
    for (int c = 1; c <= 9; c++) begin
      sample();
      chk("starve_gnt", 32'(bus.ld_gnt), (c == 9 && GUARD) ? 32'd0 : 32'd1);
      if (bus.data_sram_en && bus.data_sram_we != 4'h0) begin
        drains++;
        chk("starve_drain_addr", bus.data_sram_addr, 32'h900);
      end
      tick();
    end
    chk("starve_drains", 32'(drains), GUARD ? 32'd1 : 32'd0);
    sample();
    chk("starve_empty", 32'(bus.sq_empty), GUARD ? 32'd1 : 32'd0);
    drive_ld(1'b0, '0);
    tick();
    sample();
    chk("starve_final_empty", 32'(bus.sq_empty), 32'd1);
    tick();

    // Asynchronous reset in the middle of traffic discards the queue.
    drive_ld(1'b1, 32'hC00);
    drive_st(1'b1, 32'hB00, 32'h1234_5678, 4'hF);
    tick();
    drive_st(1'b1, 32'hB04, 32'h8765_4321, 4'hF);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_st_ready", 32'(bus.st_ready), 32'd1);
    chk("arst_sq_empty", 32'(bus.sq_empty), 32'd1);
    chk("arst_en",       32'(bus.data_sram_en), 32'd0);
    chk("arst_gnt",      32'(bus.ld_gnt), 32'd0);
    chk("arst_stall",    32'(bus.ld_stall), 32'd0);
    drive_ld(1'b0, '0);
    drive_st(1'b0, '0, '0, '0);
    tick();
    resetn = 1'b1;
    sample();
    chk("arst_lost_en",    32'(bus.data_sram_en), 32'd0);
    chk("arst_lost_empty", 32'(bus.sq_empty), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
